// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source mask/mode/pending registers, highest-index
// priority, and a request/acknowledge/EOI handshake with the CPU.
module irq_ctrl #(
    parameter int N = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  irq_in,
    input  logic [1:0]    addr,
    input  logic          we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    input  logic          int_ack,
    output logic [N-1:0]  hwint
);

    localparam int IW = 3;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        SERVICE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   id_q;
    logic [IW-1:0]   id_d;
    logic [N-1:0]    hwint_q;
    logic [N-1:0]    hwint_d;

    logic [N-1:0]    mask_q;
    logic [N-1:0]    mode_q;
    logic [N-1:0]    epend_q;
    logic [N-1:0]    smp_q;
    logic [N-1:0]    prv_q;
    logic            primed_q;

    logic [N-1:0]    pend;
    logic [N-1:0]    elig;
    logic [N-1:0]    rise;
    logic [N-1:0]    w1c;
    logic [N-1:0]    ack_clr;
    logic [N-1:0]    cur_oh;
    logic [IW-1:0]   win;
    logic            any_elig;
    logic            id_elig;
    logic            mask_we;
    logic            mode_we;
    logic            eoi;
    logic            unused;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] id);
        logic [N-1:0] oh;
        oh = '0;
        for (int i = 0; i < N; i++) begin
            if (IW'(i) == id) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    assign unused   = ^wdata[31:N];

    assign mask_we  = we && (addr == 2'd0);
    assign mode_we  = we && (addr == 2'd2);
    assign eoi      = we && (addr == 2'd3);
    assign w1c      = (we && (addr == 2'd1)) ? wdata[N-1:0] : '0;

    // Level sources mirror the sample; edge sources use the sticky bit.
    assign pend     = (mode_q & epend_q) | (~mode_q & smp_q);
    assign elig     = pend & mask_q;
    assign any_elig = |elig;
    assign rise     = smp_q & ~prv_q;

    assign cur_oh   = onehot(id_q);
    assign id_elig  = |(elig & cur_oh);

    always_comb begin
        win = '0;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                win = IW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        hwint_d = hwint_q;
        ack_clr = '0;
        unique case (state_q)
            IDLE: begin
                hwint_d = '0;
                if (any_elig) begin
                    state_d = ASSERT;
                    id_d    = win;
                    hwint_d = onehot(win);
                end
            end
            ASSERT: begin
                if (int_ack) begin
                    state_d = SERVICE;
                    hwint_d = '0;
                    ack_clr = cur_oh & mode_q;
                end else if (!id_elig) begin
                    state_d = IDLE;
                    hwint_d = '0;
                end
            end
            SERVICE: begin
                hwint_d = '0;
                if (eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                hwint_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            hwint_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            hwint_q <= hwint_d;
        end
    end

    // First sample after reset also seeds prv so a line already high
    // at release is not seen as a rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            smp_q    <= '0;
            prv_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            smp_q    <= irq_in;
            prv_q    <= primed_q ? smp_q : irq_in;
            primed_q <= 1'b1;
        end
    end

    // Set is OR-ed in after the clears so a simultaneous set wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epend_q <= '0;
        end else begin
            epend_q <= mode_q & ((epend_q & ~w1c & ~ack_clr) | rise);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            mode_q <= '0;
        end else begin
            if (mask_we) begin
                mask_q <= wdata[N-1:0];
            end
            if (mode_we) begin
                mode_q <= wdata[N-1:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (addr)
            2'd0: rdata[N-1:0] = mask_q;
            2'd1: rdata[N-1:0] = pend;
            2'd2: rdata[N-1:0] = mode_q;
            2'd3: begin
                rdata[8]      = (state_q == SERVICE);
                rdata[IW-1:0] = (state_q != IDLE) ? id_q : '0;
            end
            default: rdata = '0;
        endcase
    end

    assign hwint = hwint_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a behavioural model.
module tb_irq_ctrl;

    localparam int N = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  irq_in = '0;
    logic [1:0]    addr = '0;
    logic          we = 1'b0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          int_ack = 1'b0;
    logic [N-1:0]  hwint;

    irq_ctrl #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .int_ack (int_ack),
        .hwint   (hwint)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: per-source bit arrays, request/service ids (-1 = none).
    bit m_mask [N];
    bit m_mode [N];
    bit m_ep   [N];
    bit m_smp  [N];
    bit m_prv  [N];
    bit m_primed;
    int m_req;
    int m_svc;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mask[i] = 0;
            m_mode[i] = 0;
            m_ep[i]   = 0;
            m_smp[i]  = 0;
            m_prv[i]  = 0;
        end
        m_primed = 0;
        m_req    = -1;
        m_svc    = -1;
    endtask

    task automatic model_edge(input logic [N-1:0] irq, input logic [1:0] a,
                              input logic w, input logic [31:0] d,
                              input logic ack);
        bit el [N];
        int clr;
        bit eoi;
        bit r;
        bit keep;
        clr = -1;
        eoi = w && (a == 2'd3);
        for (int i = 0; i < N; i++) begin
            el[i] = (m_mode[i] ? m_ep[i] : m_smp[i]) && m_mask[i];
        end
        if (m_svc >= 0) begin
            if (eoi) m_svc = -1;
        end else if (m_req >= 0) begin
            if (ack) begin
                if (m_mode[m_req]) clr = m_req;
                m_svc = m_req;
                m_req = -1;
            end else if (!el[m_req]) begin
                m_req = -1;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (el[i]) m_req = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            r    = m_smp[i] && !m_prv[i];
            keep = m_ep[i] && !(w && a == 2'd1 && d[i]) && (i != clr);
            m_ep[i] = m_mode[i] && (r || keep);
        end
        for (int i = 0; i < N; i++) begin
            if (w && a == 2'd0) m_mask[i] = d[i];
            if (w && a == 2'd2) m_mode[i] = d[i];
        end
        for (int i = 0; i < N; i++) begin
            m_prv[i] = m_primed ? m_smp[i] : irq[i];
            m_smp[i] = irq[i];
        end
        m_primed = 1;
    endtask

    function automatic logic [31:0] model_hw();
        return (m_req >= 0) ? (32'd1 << m_req) : 32'd0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        logic [31:0] v;
        int id;
        v = '0;
        case (a)
            2'd0: for (int i = 0; i < N; i++) v[i] = m_mask[i];
            2'd1: for (int i = 0; i < N; i++) v[i] = m_mode[i] ? m_ep[i] : m_smp[i];
            2'd2: for (int i = 0; i < N; i++) v[i] = m_mode[i];
            default: begin
                id = (m_svc >= 0) ? m_svc : ((m_req >= 0) ? m_req : 0);
                v  = {23'd0, (m_svc >= 0), 5'd0, 3'(id)};
            end
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a,
                          input logic [31:0] exp);
        addr = a;
        we   = 1'b0;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic cyc(input logic [N-1:0] irq, input logic [1:0] a,
                       input logic w, input logic [31:0] d, input logic ack);
        irq_in  = irq;
        addr    = a;
        we      = w;
        wdata   = d;
        int_ack = ack;
        @(posedge clk);
        #1;
        model_edge(irq, a, w, d, ack);
        we      = 1'b0;
        int_ack = 1'b0;
    endtask

    task automatic idle();
        cyc(irq_in, 2'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(irq_in, a, 1'b1, d, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        idle();
    endtask

    typedef struct {
        logic [N-1:0] irq;
        logic [1:0]   a;
        logic         w;
        logic [31:0]  d;
        logic         ack;
        logic [N-1:0] hw;
        logic [1:0]   ra;
        logic [31:0]  rd;
    } vec_t;

    vec_t tbl [19];

    initial begin
        logic [N-1:0] ri;
        logic [1:0]   ra;
        logic         rw;
        logic         rk;

        tbl[0]  = '{6'h00, 2'd2, 1'b1, 32'h3F, 1'b0, 6'h00, 2'd2, 32'h3F};
        tbl[1]  = '{6'h00, 2'd0, 1'b1, 32'h01, 1'b0, 6'h00, 2'd0, 32'h01};
        tbl[2]  = '{6'h01, 2'd0, 1'b0, 32'h00, 1'b0, 6'h00, 2'd1, 32'h00};
        tbl[3]  = '{6'h00, 2'd0, 1'b0, 32'h00, 1'b0, 6'h00, 2'd1, 32'h01};
        tbl[4]  = '{6'h00, 2'd0, 1'b0, 32'h00, 1'b0, 6'h01, 2'd1, 32'h01};
        tbl[5]  = '{6'h00, 2'd0, 1'b0, 32'h00, 1'b1, 6'h00, 2'd1, 32'h00};
        tbl[6]  = '{6'h00, 2'd0, 1'b0, 32'h00, 1'b0, 6'h00, 2'd3, 32'h100};
        tbl[7]  = '{6'h00, 2'd3, 1'b1, 32'h00, 1'b0, 6'h00, 2'd3, 32'h000};
        tbl[8]  = '{6'h00, 2'd0, 1'b1, 32'h07, 1'b0, 6'h00, 2'd0, 32'h07};
        tbl[9]  = '{6'h05, 2'd0, 1'b0, 32'h00, 1'b0, 6'h00, 2'd1, 32'h00};
        tbl[10] = '{6'h05, 2'd0, 1'b0, 32'h00, 1'b0, 6'h00, 2'd1, 32'h05};
        tbl[11] = '{6'h05, 2'd0, 1'b0, 32'h00, 1'b1, 6'h04, 2'd1, 32'h05};
        tbl[12] = '{6'h05, 2'd3, 1'b1, 32'h00, 1'b0, 6'h04, 2'd3, 32'h002};
        tbl[13] = '{6'h05, 2'd0, 1'b0, 32'h00, 1'b1, 6'h00, 2'd1, 32'h01};
        tbl[14] = '{6'h05, 2'd0, 1'b0, 32'h00, 1'b0, 6'h00, 2'd3, 32'h102};
        tbl[15] = '{6'h05, 2'd3, 1'b1, 32'h00, 1'b0, 6'h00, 2'd3, 32'h000};
        tbl[16] = '{6'h05, 2'd0, 1'b0, 32'h00, 1'b0, 6'h01, 2'd3, 32'h000};
        tbl[17] = '{6'h05, 2'd0, 1'b0, 32'h00, 1'b1, 6'h00, 2'd1, 32'h00};
        tbl[18] = '{6'h00, 2'd3, 1'b1, 32'h00, 1'b0, 6'h00, 2'd3, 32'h000};

        model_reset();
        #1;
        check("reset hwint", 32'(hwint), 32'd0);
        rd_chk("reset mask", 2'd0, 32'd0);
        rd_chk("reset pend", 2'd1, 32'd0);
        rd_chk("reset mode", 2'd2, 32'd0);
        rd_chk("reset isr", 2'd3, 32'd0);
        do_reset();

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].irq, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].ack);
            check($sformatf("vec%0d hwint", i), 32'(hwint), 32'(tbl[i].hw));
            rd_chk($sformatf("vec%0d rdata", i), tbl[i].ra, tbl[i].rd);
        end

        // Withdraw: level source 1 requested, then masked before ack.
        do_reset();
        cyc(6'h02, 2'd0, 1'b1, 32'h02, 1'b0);
        idle();
        check("wd request", 32'(hwint), 32'h02);
        wr(2'd0, 32'h00);
        idle();
        check("wd hwint", 32'(hwint), 32'h00);
        rd_chk("wd isr", 2'd3, 32'h000);
        rd_chk("wd pend", 2'd1, 32'h02);

        // Set/clear race on PEND[3].
        wr(2'd2, 32'h3F);
        cyc(6'h08, 2'd0, 1'b0, 32'd0, 1'b0);
        cyc(6'h00, 2'd0, 1'b0, 32'd0, 1'b0);
        rd_chk("race pre", 2'd1, 32'h08);
        cyc(6'h08, 2'd0, 1'b0, 32'd0, 1'b0);
        cyc(6'h08, 2'd1, 1'b1, 32'h08, 1'b0);
        rd_chk("race set wins", 2'd1, 32'h08);
        cyc(6'h08, 2'd1, 1'b1, 32'h08, 1'b0);
        rd_chk("w1c clears", 2'd1, 32'h00);

        // Reset mid-SERVICE with irq_in[0] held high across release.
        cyc(6'h00, 2'd0, 1'b1, 32'h01, 1'b0);
        cyc(6'h01, 2'd0, 1'b0, 32'd0, 1'b0);
        cyc(6'h00, 2'd0, 1'b0, 32'd0, 1'b0);
        idle();
        check("svc request", 32'(hwint), 32'h01);
        cyc(6'h00, 2'd0, 1'b0, 32'd0, 1'b1);
        rd_chk("svc isr", 2'd3, 32'h100);
        irq_in = 6'h01;
        reset  = 1'b0;
        model_reset();
        #1;
        check("rst hwint", 32'(hwint), 32'd0);
        rd_chk("rst isr", 2'd3, 32'd0);
        rd_chk("rst mask", 2'd0, 32'd0);
        rd_chk("rst pend", 2'd1, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        cyc(6'h01, 2'd2, 1'b1, 32'h3F, 1'b0);
        cyc(6'h01, 2'd0, 1'b1, 32'h01, 1'b0);
        idle();
        idle();
        rd_chk("release pend", 2'd1, 32'h00);
        check("release hwint", 32'(hwint), 32'd0);

        do_reset();
        for (int k = 0; k < 800; k++) begin
            ri = irq_in ^ N'($urandom & $urandom);
            ra = 2'($urandom_range(0, 3));
            rw = ($urandom_range(0, 3) == 0);
            rk = (hwint != '0) ? ($urandom_range(0, 2) == 0)
                               : ($urandom_range(0, 9) == 0);
            cyc(ri, ra, rw, $urandom, rk);
            check("rnd hwint", 32'(hwint), model_hw());
            ra = 2'($urandom_range(0, 3));
            rd_chk("rnd reg", ra, model_rd(ra));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
